// File: rtl/logic_axi4_stream_to_avalon_st_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : logic_axi4_stream_to_avalon_st_multichannel
// Description : AXI4-Stream (interleaved TID channels) to Avalon-ST bridge
//               with a 2-entry skid FIFO and per-channel SOP tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_axi4_stream_to_avalon_st_multichannel #(
    parameter int TDATA_BYTES = 4,
    parameter int TID_WIDTH   = 2,
    parameter int TUSER_WIDTH = 1,
    parameter int ERROR_WIDTH = 2,
    parameter int EMPTY_WIDTH = (TDATA_BYTES < 2) ? 1 : $clog2(TDATA_BYTES)
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       rx_tvalid,
    output logic                       rx_tready,
    input  logic [TDATA_BYTES*8-1:0]   rx_tdata,
    input  logic [TDATA_BYTES-1:0]     rx_tkeep,
    input  logic                       rx_tlast,
    input  logic [TID_WIDTH-1:0]       rx_tid,
    input  logic [TUSER_WIDTH-1:0]     rx_tuser,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [TDATA_BYTES*8-1:0]   tx_data,
    output logic                       tx_startofpacket,
    output logic                       tx_endofpacket,
    output logic [TID_WIDTH-1:0]       tx_channel,
    output logic [ERROR_WIDTH-1:0]     tx_error,
    output logic [EMPTY_WIDTH-1:0]     tx_empty
);

    localparam int c_DATA_W   = TDATA_BYTES * 8;
    localparam int c_CHANNELS = 1 << TID_WIDTH;
    localparam int c_ENT_W    = c_DATA_W + TID_WIDTH + ERROR_WIDTH + EMPTY_WIDTH + 2;
    localparam logic [EMPTY_WIDTH-1:0] c_BYTES_E     = EMPTY_WIDTH'(TDATA_BYTES);
    localparam logic [EMPTY_WIDTH-1:0] c_EMPTY_SAT   = EMPTY_WIDTH'(TDATA_BYTES - 1);
    localparam logic [TDATA_BYTES-1:0] c_KEEP_ONE    = TDATA_BYTES'(1);

    logic [c_ENT_W-1:0]     r_mem [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;
    logic                   r_ready;
    logic [c_CHANNELS-1:0]  r_in_packet;

    logic                   w_accept;
    logic                   w_null;
    logic                   w_push;
    logic                   w_pop;
    logic [1:0]             w_count_next;
    logic [c_DATA_W-1:0]    w_data;
    logic [EMPTY_WIDTH:0]   w_ones;
    logic [EMPTY_WIDTH-1:0] w_empty;
    logic [TDATA_BYTES-1:0] w_keep_p1;
    logic [ERROR_WIDTH-1:0] w_err;
    logic                   w_sop;
    logic [c_ENT_W-1:0]     w_entry;

    assign w_accept = rx_tvalid & r_ready;
    assign w_null   = ~(|rx_tkeep) & ~rx_tlast;
    assign w_push   = w_accept & ~w_null;
    assign w_pop    = (r_count != 2'd0) & tx_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Beat formatting happens at acceptance so the FIFO holds ready-to-send Avalon beats
    always_comb begin
        w_data = '0;
        w_ones = '0;
        for (int i = 0; i < TDATA_BYTES; i++) begin
            w_data[(TDATA_BYTES-1-i)*8 +: 8] = rx_tdata[i*8 +: 8];
            w_ones = w_ones + {{EMPTY_WIDTH{1'b0}}, rx_tkeep[i]};
        end

        w_empty = '0;
        if (rx_tlast) begin
            if (w_ones == '0)
                w_empty = c_EMPTY_SAT;
            else
                w_empty = c_BYTES_E - w_ones[EMPTY_WIDTH-1:0];
        end

        // keep is contiguous from byte 0 exactly when keep & (keep+1) == 0
        w_keep_p1 = rx_tkeep + c_KEEP_ONE;
        w_err     = '0;
        w_err[0]  = |rx_tuser;
        if (rx_tlast)
            w_err[1] = (rx_tkeep == '0) | ((rx_tkeep & w_keep_p1) != '0);
        else
            w_err[1] = ~(&rx_tkeep);

        w_sop   = ~r_in_packet[rx_tid];
        w_entry = {w_data, rx_tid, w_err, w_empty, w_sop, rx_tlast};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_ready     <= 1'b0;
            r_in_packet <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr]     <= w_entry;
                r_wr_ptr            <= ~r_wr_ptr;
                r_in_packet[rx_tid] <= ~rx_tlast;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= w_count_next;
            r_ready <= (w_count_next != 2'd2);
        end
    end

    assign rx_tready = r_ready;
    assign tx_valid  = (r_count != 2'd0);
    assign {tx_data, tx_channel, tx_error, tx_empty, tx_startofpacket, tx_endofpacket} = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: doc/logic_axi4_stream_to_avalon_st_multichannel.md
LOGIC_AXI4_STREAM_TO_AVALON_ST_MULTICHANNEL -- requirements
Module: logic_axi4_stream_to_avalon_st_multichannel

Interface
REQ-001 SHALL have parameter TDATA_BYTES, default 4: bytes per beat on both sides; minimum 1.
REQ-002 SHALL have parameter TID_WIDTH, default 2: channel id width; 2^TID_WIDTH independent interleaved channels.
REQ-003 SHALL have parameter TUSER_WIDTH, default 1: width of rx_tuser.
REQ-004 SHALL have parameter ERROR_WIDTH, default 2: width of tx_error; minimum 2.
REQ-005 SHALL have parameter EMPTY_WIDTH, default clog2(TDATA_BYTES), or 1 if TDATA_BYTES<2: width of tx_empty.
REQ-006 SHALL have port aclk, input, 1: single clock; all logic on the rising edge.
REQ-007 SHALL have port areset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have ports rx_tvalid/rx_tlast, input, 1 each: AXI4-Stream valid and last.
REQ-009 SHALL have port rx_tready, output, 1: AXI4-Stream ready, driven directly from a register.
REQ-010 SHALL have ports rx_tdata (TDATA_BYTES x 8), rx_tkeep (TDATA_BYTES), rx_tid (TID_WIDTH), rx_tuser (TUSER_WIDTH), all inputs.
REQ-011 SHALL have ports tx_valid, tx_startofpacket, tx_endofpacket, output, 1 each; tx_ready, input, 1.
REQ-012 SHALL have outputs tx_data (TDATA_BYTES x 8), tx_channel (TID_WIDTH), tx_error (ERROR_WIDTH), tx_empty (EMPTY_WIDTH).

Function
REQ-013 SHALL accept an rx beat when rx_tvalid and rx_tready are both 1 in the same cycle.
REQ-014 SHALL buffer beats in a 2-entry skid FIFO; rx_tready is 1 when fewer than 2 entries are held, or when 2 are held and tx_ready was sampled 1. It SHALL sustain 1 beat/cycle with tx_ready held 1.
REQ-015 SHALL present an accepted beat on tx_valid exactly 1 cycle after acceptance when the FIFO was empty; order across all channels SHALL be preserved.
REQ-016 SHALL hold all tx_* outputs stable while tx_valid=1 and tx_ready=0; a beat SHALL leave when tx_valid and tx_ready are both 1.
REQ-017 SHALL drop an accepted null beat (rx_tkeep all 0, rx_tlast 0) without output and without changing channel state.
REQ-018 SHALL keep a per-channel in_packet bit: tx_startofpacket = NOT in_packet[rx_tid] at acceptance; an accepted non-null beat with tlast=0 sets the bit; one with tlast=1 clears it.
REQ-019 SHALL set tx_endofpacket = rx_tlast and tx_channel = rx_tid.
REQ-020 SHALL byte-reverse data: tx_data byte (TDATA_BYTES-1-i) = rx_tdata byte i, so AXI byte 0 is the first Avalon symbol in the MSBs.
REQ-021 SHALL set tx_empty = TDATA_BYTES - popcount(rx_tkeep) on last beats (saturated at TDATA_BYTES-1), and 0 on non-last beats.
REQ-022 SHALL set tx_error[0] = OR of all rx_tuser bits.
REQ-023 SHALL set tx_error[1] = 1 when: a non-last beat has rx_tkeep not all 1; or a last beat has rx_tkeep = 0; or a last beat has rx_tkeep not of form 2^n-1 (non-contiguous from byte 0). tx_error bits above bit 1 SHALL be 0.
REQ-024 SHALL forward tkeep-violating beats with error set, not drop them; SOP/EOP tracking is unchanged.
REQ-025 SHALL handle a simultaneous push and pop with 2 entries held without loss or duplication.

Reset
REQ-026 SHALL, while areset=1, drive tx_valid=0, rx_tready=0, tx_startofpacket=0, tx_endofpacket=0, tx_data/tx_channel/tx_error/tx_empty=0; SHALL clear FIFO and all in_packet bits.
REQ-027 SHALL drive rx_tready=1 in the first cycle after areset falls.
REQ-028 SHALL, on reset mid-packet, discard buffered beats; the next accepted beat on any channel has tx_startofpacket=1.

Verification
REQ-029 Single packet ch 0: 3 beats, tkeep last=4'b0011, tx_ready=1 -> 3 tx beats 1 cycle late, SOP on beat 0, EOP+empty=2 on beat 2, error=0.
REQ-030 Interleave ch1 beat0, ch2 beat0, ch1 last, ch2 last -> SOP=1 on first two, EOP on last two, tx_channel 1,2,1,2.
REQ-031 tx_ready held 0 while streaming -> exactly 2 beats absorbed, rx_tready=0 next cycle; tx outputs stable; release -> no loss, order kept.
REQ-032 Last beat tkeep=4'b0101 -> forwarded, tx_error[1]=1; null beat (tkeep=0, tlast=0) -> no tx beat.
REQ-033 rx_tdata=32'h44332211 -> tx_data=32'h11223344; rx_tuser=1 -> tx_error[0]=1.
REQ-034 areset asserted after ch3 beat 0 -> outputs 0; after release, ch3 beat has SOP=1.
